mcdf_ctrl_regs: RTL

Parametrised MCDF control/status register file for NUM_CH slave channels. It decodes the single-port command bus, holds per-channel control registers (enable, priority, packet length) and read-only status registers (FIFO margin). It drives the per-channel configuration to the arbiter and formatter. Compared with the earlier 3-channel register file, it adds separate read/write strobes, read-data valid, access-error reporting, enforcement of read-only registers and a packet-length clamp.

---
 rtl/mcdf_ctrl_regs_if.sv | 23 ++
 rtl/mcdf_ctrl_regs.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mcdf_ctrl_regs_if.sv
// Command bus between the MCDF host and the control/status register file.
// Host drives command/address/write data; the register file returns read data and strobes.
interface mcdf_ctrl_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic [1:0]        cmd_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic [DATA_W-1:0] cmd_data_o;
    logic              cmd_rvalid_o;
    logic              cmd_err_o;

    modport master (
        output cmd_i, cmd_addr_i, cmd_data_i,
        input  cmd_data_o, cmd_rvalid_o, cmd_err_o
    );

    modport slave (
        input  cmd_i, cmd_addr_i, cmd_data_i,
        output cmd_data_o, cmd_rvalid_o, cmd_err_o
    );
endinterface

// File: rtl/mcdf_ctrl_regs.sv
// MCDF control/status register file for NUM_CH channels: CTRL (en/prio/pkglen) and read-only STAT.
// Optional write-once LOCK register at 0x7C is built when MCDF_CTRL_LOCK_EN is defined.
module mcdf_ctrl_regs #(
    parameter int          NUM_CH       = 3,
    parameter int          ADDR_W       = 8,
    parameter int          DATA_W       = 32,
    parameter int          MARGIN_W     = 7,
    parameter int          FIFO_DEPTH   = 64,
    parameter logic [5:0]  CTRL_DEFAULT = 6'h07
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    mcdf_ctrl_regs_if.slave            bus,
    input  logic [MARGIN_W*NUM_CH-1:0] slv_margin_i,
    output logic [NUM_CH-1:0]          slv_en_o,
    output logic [2*NUM_CH-1:0]        slv_prio_o,
    output logic [3*NUM_CH-1:0]        slv_pkglen_o
);
    localparam int WORD_W     = ADDR_W - 2;
    localparam int STAT_WORD  = 16;   // 0x40 >> 2
    localparam int LOCK_WORD  = 31;   // 0x7C >> 2

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_WR   = 2'b01,
        CMD_RD   = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

    logic [5:0]          ctrl_q [NUM_CH];
    logic [5:0]          ctrl_d [NUM_CH];
    logic [MARGIN_W-1:0] stat_q [NUM_CH];
    logic [MARGIN_W-1:0] stat_d [NUM_CH];
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                locked;
    logic [31:0]         word_idx;
    logic                aligned;
    logic                hit;
    logic                unused_wdata;

`ifdef MCDF_CTRL_LOCK_EN
    logic lock_q, lock_d;
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    assign unused_wdata = ^bus.cmd_data_i[DATA_W-1:6];

    // Out-of-range pkglen codes saturate to the largest legal code (64 words).
    function automatic logic [5:0] ctrl_sanitize(input logic [5:0] w);
        logic [2:0] len;
        len = (w[5:3] > 3'd4) ? 3'd4 : w[5:3];
        return {len, w[2:0]};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        ctrl_d   = ctrl_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        hit      = 1'b0;
`ifdef MCDF_CTRL_LOCK_EN
        lock_d   = lock_q;
`endif
        word_idx = {{(32-WORD_W){1'b0}}, bus.cmd_addr_i[ADDR_W-1:2]};
        aligned  = (bus.cmd_addr_i[1:0] == 2'b00);
        for (int c = 0; c < NUM_CH; c++) begin
            stat_d[c] = slv_margin_i[c*MARGIN_W +: MARGIN_W];
        end

        case (bus.cmd_i)
            CMD_WR: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (aligned && word_idx == c) begin
                        hit = 1'b1;
                        if (locked) err_d = 1'b1;
                        else        ctrl_d[c] = ctrl_sanitize(bus.cmd_data_i[5:0]);
                    end
                    if (aligned && word_idx == STAT_WORD + c) begin
                        hit   = 1'b1;
                        err_d = 1'b1;
                    end
                end
`ifdef MCDF_CTRL_LOCK_EN
                if (aligned && word_idx == LOCK_WORD) begin
                    hit = 1'b1;
                    if (bus.cmd_data_i[0]) lock_d = 1'b1;
                end
`endif
                if (!hit) err_d = 1'b1;
            end
            CMD_RD: begin
                rvalid_d = 1'b1;
                rdata_d  = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (aligned && word_idx == c) begin
                        hit     = 1'b1;
                        rdata_d = DATA_W'(ctrl_q[c]);
                    end
                    if (aligned && word_idx == STAT_WORD + c) begin
                        hit     = 1'b1;
                        rdata_d = DATA_W'(stat_q[c]);
                    end
                end
`ifdef MCDF_CTRL_LOCK_EN
                if (aligned && word_idx == LOCK_WORD) begin
                    hit     = 1'b1;
                    rdata_d = DATA_W'(lock_q);
                end
`endif
                if (!hit) err_d = 1'b1;
            end
            CMD_ILL: err_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the register arrays are control state, not RAM, so every entry is reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ctrl_q[c] <= CTRL_DEFAULT;
                stat_q[c] <= MARGIN_W'(FIFO_DEPTH);
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            ctrl_q   <= ctrl_d;
            stat_q   <= stat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

`ifdef MCDF_CTRL_LOCK_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) lock_q <= 1'b0;
        else         lock_q <= lock_d;
    end
`endif

    assign bus.cmd_data_o   = rdata_q;
    assign bus.cmd_rvalid_o = rvalid_q;
    assign bus.cmd_err_o    = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg
        assign slv_en_o[g]         = ctrl_q[g][0];
        assign slv_prio_o[2*g +: 2]   = ctrl_q[g][2:1];
        assign slv_pkglen_o[3*g +: 3] = ctrl_q[g][5:3];
    end
endmodule
